// File: rtl/dffram_pkg.sv
// Shared defaults and FSM state type for the DFF RAM write-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dffram_pkg;

    localparam int AW_DEF         = 5;           // byte address width
    localparam int DW_DEF         = 8;           // requester byte width
    localparam int NIBBLE_W_DEF   = DW_DEF / 2;  // RAM write-port width
    localparam int ADDR_LIMIT_DEF = 28;          // first unimplemented byte

    // IDLE: no byte in flight. WR_LO/WR_HI: low/high nibble on the RAM port.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } wr_state_t;

endpackage

// File: rtl/dffram_rr_arb2.sv
// Two-way round-robin grant; a tie goes to the requester not granted last.
// Latency: grant is combinational from req; pointer updates on the advance edge.
// Backpressure: none; advance is asserted by the owner only when a grant is taken.
// Ports: clk/rst (sync, active-high), req[1:0], advance, grant[1:0] (one-hot or zero).
module dffram_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // 1 = requester 1 was granted last, so requester 0 wins the first tie.
    logic last;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
        end else if (advance) begin
            last <= grant[1];
        end
    end

endmodule

// File: rtl/dffram_wr_arbiter.sv
// Arbitrates two byte-write requesters onto the nibble-wide write port of a 2R1W DFF RAM.
// Latency: accepted byte's low nibble is written in the next cycle and its high nibble
//          in the cycle after; one byte per 2 cycles sustained.
// Backpressure: req_ready is offered only in IDLE or WR_HI, to the single granted requester.
// Ports: clk, rst (sync, active-high); req_valid/req_ready[1:0], req_addr0/1, req_data0/1;
//        ram_wen, ram_addr, ram_wdata (DW/2), ram_half; wr_done[1:0]; busy.
// Optional: DFFRAM_ARB_ADDR_CHECK_EN suppresses writes to addr >= ADDR_LIMIT and adds addr_err.
module dffram_wr_arbiter
    import dffram_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int ADDR_LIMIT = ADDR_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [AW-1:0]     req_addr0,
    input  logic [AW-1:0]     req_addr1,
    input  logic [DW-1:0]     req_data0,
    input  logic [DW-1:0]     req_data1,
    output logic              ram_wen,
    output logic [AW-1:0]     ram_addr,
    output logic [DW/2-1:0]   ram_wdata,
    output logic              ram_half,
    output logic [1:0]        wr_done,
`ifdef DFFRAM_ARB_ADDR_CHECK_EN
    output logic              addr_err,
`endif
    output logic              busy
);

    localparam int NW = DW / 2;

    wr_state_t         state;
    logic [1:0]        grant;
    logic              can_accept;
    logic              accept;
    logic [AW-1:0]     sel_addr;
    logic [DW-1:0]     sel_data;
    logic [NW-1:0]     lat_hi;   // high nibble held for the WR_HI cycle
    logic              lat_idx;  // requester owning the byte in flight
`ifdef DFFRAM_ARB_ADDR_CHECK_EN
    logic              sel_ok;
    logic              lat_ok;
`endif

    dffram_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (accept),
        .grant   (grant)
    );

    // A new byte can be taken while idle or while the previous high nibble is going out,
    // which is what keeps the write port busy every cycle under back-to-back traffic.
    assign can_accept = !rst && ((state == IDLE) || (state == WR_HI));
    assign req_ready  = can_accept ? grant : 2'b00;
    assign accept     = |(req_valid & req_ready);
    assign sel_addr   = grant[1] ? req_addr1 : req_addr0;
    assign sel_data   = grant[1] ? req_data1 : req_data0;
    assign busy       = (state != IDLE);

`ifdef DFFRAM_ARB_ADDR_CHECK_EN
    assign sel_ok = (32'(sel_addr) < 32'(ADDR_LIMIT));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ram_wen   <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_half  <= 1'b0;
            wr_done   <= 2'b00;
            lat_hi    <= '0;
            lat_idx   <= 1'b0;
`ifdef DFFRAM_ARB_ADDR_CHECK_EN
            addr_err  <= 1'b0;
            lat_ok    <= 1'b1;
`endif
        end else begin
            wr_done  <= 2'b00;
`ifdef DFFRAM_ARB_ADDR_CHECK_EN
            addr_err <= 1'b0;
`endif
            case (state)
                IDLE, WR_HI: begin
                    if (accept) begin
                        state     <= WR_LO;
                        lat_hi    <= sel_data[DW-1:NW];
                        lat_idx   <= grant[1];
                        ram_addr  <= sel_addr;
                        ram_half  <= 1'b0;
                        ram_wdata <= sel_data[NW-1:0];
`ifdef DFFRAM_ARB_ADDR_CHECK_EN
                        ram_wen   <= sel_ok;
                        lat_ok    <= sel_ok;
`else
                        ram_wen   <= 1'b1;
`endif
                    end else begin
                        // ram_addr deliberately keeps its last value when idle.
                        state     <= IDLE;
                        ram_wen   <= 1'b0;
                        ram_half  <= 1'b0;
                        ram_wdata <= '0;
                    end
                end
                WR_LO: begin
                    state     <= WR_HI;
                    ram_half  <= 1'b1;
                    ram_wdata <= lat_hi;
                    wr_done   <= lat_idx ? 2'b10 : 2'b01;
`ifdef DFFRAM_ARB_ADDR_CHECK_EN
                    ram_wen   <= lat_ok;
                    addr_err  <= !lat_ok;
`else
                    ram_wen   <= 1'b1;
`endif
                end
                default: begin
                    state   <= IDLE;
                    ram_wen <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dffram_wr_arbiter.sv
// Self-checking bench: directed scenarios then randomized traffic against a grant/nibble model.
// Latency: n/a (testbench).
// Backpressure: requesters hold valid until the model-predicted ready arrives or change randomly.
module tb_dffram_wr_arbiter;

    localparam int AW    = 5;
    localparam int DW    = 8;
    localparam int NW    = 4;
    localparam int LIMIT = 28;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    req_valid = 2'b00;
    logic [1:0]    req_ready;
    logic [AW-1:0] req_addr0 = '0;
    logic [AW-1:0] req_addr1 = '0;
    logic [DW-1:0] req_data0 = '0;
    logic [DW-1:0] req_data1 = '0;
    logic          ram_wen;
    logic [AW-1:0] ram_addr;
    logic [NW-1:0] ram_wdata;
    logic          ram_half;
    logic [1:0]    wr_done;
    logic          busy;
`ifdef DFFRAM_ARB_ADDR_CHECK_EN
    logic          addr_err;
`endif

    dffram_wr_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr0 (req_addr0),
        .req_addr1 (req_addr1),
        .req_data0 (req_data0),
        .req_data1 (req_data1),
        .ram_wen   (ram_wen),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_half  (ram_half),
        .wr_done   (wr_done),
`ifdef DFFRAM_ARB_ADDR_CHECK_EN
        .addr_err  (addr_err),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;   // number of rising edges seen

    always @(posedge clk) cyc <= cyc + 1;

    // One expected RAM-port cycle.
    typedef struct {
        int            cyc;
        logic          wen;
        logic [AW-1:0] addr;
        logic          half;
        logic [NW-1:0] wdata;
        logic [1:0]    done;
        logic          err;
    } exp_t;

    exp_t expq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: decides who should be granted and what the two nibble cycles look like.
    int   next_ok = 0;     // first cycle in which a new byte may be taken
    logic m_last  = 1'b1;  // requester granted most recently

    always @(negedge clk) begin
        logic [1:0]    g;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          wen_e;
        if (cyc > 0) begin
            if (rst) begin
                check("ready_in_reset", {30'd0, req_ready}, 32'd0);
                m_last  = 1'b1;
                next_ok = 0;
                // The byte in flight is aborted: nothing after this cycle happens.
                while (expq.size() > 0 && expq[expq.size()-1].cyc > cyc)
                    void'(expq.pop_back());
            end else begin
                g = 2'b00;
                if (cyc >= next_ok) begin
                    if (req_valid == 2'b11) g = m_last ? 2'b01 : 2'b10;
                    else                    g = req_valid;
                end
                check("req_ready", {30'd0, req_ready}, {30'd0, g});
                if (g != 2'b00) begin
                    a = g[1] ? req_addr1 : req_addr0;
                    d = g[1] ? req_data1 : req_data0;
`ifdef DFFRAM_ARB_ADDR_CHECK_EN
                    wen_e = (int'(a) < LIMIT);
`else
                    wen_e = 1'b1;
`endif
                    expq.push_back('{cyc + 1, wen_e, a, 1'b0, d[3:0], 2'b00, 1'b0});
                    expq.push_back('{cyc + 2, wen_e, a, 1'b1, d[7:4], g, !wen_e});
                    m_last  = g[1];
                    next_ok = cyc + 2;
                end
            end
        end
    end

    // Monitor: compares the RAM port, wr_done and busy every cycle.
    logic [AW-1:0] hold_addr = '0;

    always @(negedge clk) begin
        exp_t e;
        if (cyc > 0) begin
            if (expq.size() > 0 && expq[0].cyc == cyc) begin
                e = expq.pop_front();
                check("busy_active", {31'd0, busy}, 32'd1);
                check("ram_wen", {31'd0, ram_wen}, {31'd0, e.wen});
                check("wr_done", {30'd0, wr_done}, {30'd0, e.done});
                if (e.wen) begin
                    check("ram_addr", {27'd0, ram_addr}, {27'd0, e.addr});
                    check("ram_half", {31'd0, ram_half}, {31'd0, e.half});
                    check("ram_wdata", {28'd0, ram_wdata}, {28'd0, e.wdata});
                end
`ifdef DFFRAM_ARB_ADDR_CHECK_EN
                check("addr_err", {31'd0, addr_err}, {31'd0, e.err});
`endif
                hold_addr = e.addr;
            end else begin
                check("busy_idle", {31'd0, busy}, 32'd0);
                check("wen_idle", {31'd0, ram_wen}, 32'd0);
                check("done_idle", {30'd0, wr_done}, 32'd0);
                check("half_idle", {31'd0, ram_half}, 32'd0);
                check("wdata_idle", {28'd0, ram_wdata}, 32'd0);
                check("addr_hold", {27'd0, ram_addr}, {27'd0, hold_addr});
`ifdef DFFRAM_ARB_ADDR_CHECK_EN
                check("addr_err_idle", {31'd0, addr_err}, 32'd0);
`endif
            end
            if (rst) hold_addr = '0;
        end
    end

    // Present one byte from requester i and hold it until it is taken (bounded wait).
    task automatic send(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit got = 1'b0;
        if (i == 1) begin
            req_addr1 = a; req_data1 = d; req_valid = 2'b10;
        end else begin
            req_addr0 = a; req_data0 = d; req_valid = 2'b01;
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL send_timeout: requester %0d never accepted, expected accept within 20 cycles", i);
        end
        @(posedge clk);
        #1 req_valid = 2'b00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single byte from requester 0.
        send(0, 5'h03, 8'hA5);
        idle(3);

        // Both requesters valid every cycle: alternating grants, port never idle.
        req_addr0 = 5'h01; req_data0 = 8'h11;
        req_addr1 = 5'h02; req_data1 = 8'h22;
        req_valid = 2'b11;
        idle(8);
        req_valid = 2'b00;
        idle(3);

        // Requester 1 back-to-back.
        for (int i = 0; i < 4; i++) send(1, 5'(8'h10 + i), 8'(8'h30 + i));
        idle(3);

        // Reset during the low-nibble cycle; valids held high while reset is asserted.
        send(0, 5'h05, 8'hF0);
        rst = 1'b1;
        req_valid = 2'b11;
        idle(2);
        rst = 1'b0;
        req_valid = 2'b00;
        idle(3);

`ifdef DFFRAM_ARB_ADDR_CHECK_EN
        // Out-of-range address: consumed but not written.
        send(0, 5'h1D, 8'h77);
        idle(3);
`endif

        // Randomized traffic with occasional reset pulses.
        repeat (3000) begin
            req_valid = 2'($urandom_range(0, 3));
            req_addr0 = AW'($urandom_range(0, 31));
            req_addr1 = AW'($urandom_range(0, 31));
            req_data0 = DW'($urandom_range(0, 255));
            req_data1 = DW'($urandom_range(0, 255));
            rst       = ($urandom_range(0, 63) == 0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        req_valid = 2'b00;
        idle(5);

        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries expected 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dffram_wr_arbiter.md
DFFRAM_WR_ARBITER -- requirements
Module: dffram_wr_arbiter

Interface
REQ-001 Parameter AW, default 5: byte address width of the 2R1W DFF RAM.
REQ-002 Parameter DW, default 8: requester byte width; RAM write port nibble width is DW/2.
REQ-003 Parameter ADDR_LIMIT, default 28: first unimplemented byte address; bytes 28..31 alias to byte 0.
REQ-004 clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  2  per-requester byte-write request, index 0/1.
REQ-007 req_ready  output  2  per-requester accept; a transfer occurs on a posedge where valid[i]&ready[i]=1.
REQ-008 req_addr0, req_addr1  input  AW each  byte address of each requester.
REQ-009 req_data0, req_data1  input  DW each  byte data of each requester.
REQ-010 ram_wen  output  1  RAM write-port nibble write enable.
REQ-011 ram_addr  output  AW  RAM write-port address.
REQ-012 ram_wdata  output  DW/2  RAM write-port nibble data.
REQ-013 ram_half  output  1  0 = bits [3:0], 1 = bits [7:4] of addressed byte.
REQ-014 wr_done  output  2  one-cycle pulse per requester when its high nibble is driven.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 FSM states IDLE, WR_LO, WR_HI; every accepted byte is written as two consecutive nibble cycles: low nibble, then high nibble.
REQ-017 req_ready[i] is high only in IDLE or WR_HI, and only for the single requester granted that cycle; never both bits high.
REQ-018 Grant: one valid -> that requester; both valid -> requester not granted last; last-grant pointer resets to 1 (requester 0 wins first tie).
REQ-019 On acceptance at edge N: addr/data latched, state -> WR_LO, pointer updated; no re-sampling of requester inputs until next acceptance.
REQ-020 Cycle N+1 (WR_LO): ram_wen=1, ram_half=0, ram_wdata=data[3:0], ram_addr=latched address; state -> WR_HI.
REQ-021 Cycle N+2 (WR_HI): ram_wen=1, ram_half=1, ram_wdata=data[7:4], wr_done[i]=1; state -> WR_LO if a new acceptance occurs this cycle, else IDLE.
REQ-022 Sustained throughput one byte per 2 cycles; ram_wen continuously high under back-to-back traffic.
REQ-023 ram_* and wr_done are registered outputs; in IDLE ram_wen=0, ram_half=0, ram_wdata=0, ram_addr holds last value.
REQ-024 No read-port involvement; arbiter never stalls RAM read ports and imposes no read/write ordering.

Reset
REQ-025 Reset values: state IDLE, req_ready=0, ram_wen=0, ram_addr=0, ram_wdata=0, ram_half=0, wr_done=0, busy=0, pointer=1.
REQ-026 Reset asserted in WR_LO/WR_HI aborts the byte; no further nibble write; a written low nibble stays in RAM; no wr_done issued.
REQ-027 req_ready held 0 on every cycle rst is high.

Configuration
REQ-028 Macro DFFRAM_ARB_ADDR_CHECK_EN defined: accepted requests with addr >= ADDR_LIMIT are consumed normally (ready, FSM, wr_done) but both nibble cycles drive ram_wen=0, and output addr_err (1 bit, reset 0) pulses in the WR_HI cycle.
REQ-029 Macro undefined: no addr_err port; all addresses written, aliasing per RAM (28..31 overwrite byte 0).

Structure
REQ-030 Package dffram_pkg holds AW, DW, NIBBLE_W, ADDR_LIMIT defaults and the FSM state enum typedef.
REQ-031 Sub-module dffram_rr_arb2: two-way round-robin grant with pointer, instantiated once.

Verification
REQ-032 Reset, then req0 addr=0x03 data=0xA5 -> WR_LO: wen=1 addr=0x03 half=0 wdata=0x5; WR_HI: half=1 wdata=0xA, wr_done=01; then IDLE.
REQ-033 Both valid every cycle, data 0x11/0x22 -> grants alternate 0,1,0,1; ram_wen continuously high; 4 bytes in 8 cycles.
REQ-034 req1 only, back-to-back 0x10..0x13 -> no IDLE gap between bytes; wr_done=10 every second cycle.
REQ-035 rst pulsed in WR_LO of byte addr=0x05 data=0xF0 -> next cycle wen=0, no wr_done, busy=0, req_ready=00 while rst high.
REQ-036 With DFFRAM_ARB_ADDR_CHECK_EN, req0 addr=0x1D -> ready/wr_done as normal, wen=0 both cycles, addr_err pulse; byte 0 unchanged on read back.
